// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions: padder FSM states, block geometry, padding byte
// and the initial chaining value used by the compression core.
package sha1_pkg;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_PAD   = 2'd1,
        S_EMIT  = 2'd2,
        S_EXTRA = 2'd3
    } state_t;

    localparam int SHA1_BLOCK_W = 512;
    localparam int SHA1_WORDS   = 16;
    localparam int SHA1_LEN_W   = 64;

    localparam logic [7:0] PAD_BYTE = 8'h80;

    // H0..H4, H0 in the most significant word.
    localparam logic [159:0] SHA1_IV = {
        32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0
    };

endpackage

// File: rtl/sha1_byte_mask.sv
// Per-word byte lane helper: keep-mask for the valid left-aligned bytes and
// the 0x80 terminator placed in the first unused lane (none for a full word).
module sha1_byte_mask
    import sha1_pkg::*;
(
    input  logic [2:0]  nbytes,
    output logic [31:0] keep,
    output logic [31:0] pad,
    output logic [2:0]  eff_nbytes,
    output logic        full
);

    // Counts above four cannot occur in a 32-bit word; treat them as full.
    assign eff_nbytes = (nbytes > 3'd4) ? 3'd4 : nbytes;
    assign full       = (eff_nbytes == 3'd4);

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_lane
        assign keep[31-8*gi -: 8] = (3'(gi) < eff_nbytes)  ? 8'hFF    : 8'h00;
        assign pad[31-8*gi -: 8]  = (3'(gi) == eff_nbytes) ? PAD_BYTE : 8'h00;
    end

endmodule

// File: rtl/sha1_padder.sv
// SHA-1 message padder: packs 32-bit big-endian message words into 512-bit
// blocks, appends 0x80, zero fill and the 64-bit bit length, and presents
// each block with first/last flags on a valid/ready interface.
module sha1_padder
    import sha1_pkg::*;
#(
    parameter int LEN_W = SHA1_LEN_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [31:0]  msg_data,
    input  logic [2:0]   msg_nbytes,
    input  logic         msg_last,
    input  logic         msg_valid,
    output logic         msg_ready,
    output logic [511:0] blk_data,
    output logic         blk_first,
    output logic         blk_last,
    output logic         blk_valid,
    input  logic         blk_ready
);

    localparam logic [31:0] PAD_WORD = {PAD_BYTE, 24'h000000};

    state_t           state;
    logic [31:0]      blk_buf  [SHA1_WORDS];
    logic [31:0]      pad_fill [SHA1_WORDS];
    logic [3:0]       widx;
    logic [LEN_W-1:0] len;
    logic [2:0]       last_nb;
    logic             first_f;
    logic             last_f;
    logic             need80;
    logic             needlen;

    logic [2:0]       nb_sel;
    logic [2:0]       eff_nb;
    logic [31:0]      keep;
    logic [31:0]      pad;
    logic             word_full;
    logic [6:0]       pad_off;

    // While padding, the mask looks at the stored byte count of the final word.
    assign nb_sel = (state == S_PAD) ? last_nb : msg_nbytes;

    sha1_byte_mask u_mask (
        .nbytes     (nb_sel),
        .keep       (keep),
        .pad        (pad),
        .eff_nbytes (eff_nb),
        .full       (word_full)
    );

    // Byte offset just past the final message byte within the block (0..64).
    assign pad_off = {1'b0, widx, 2'b00} + {4'b0000, last_nb};

    genvar gi;
    for (gi = 0; gi < SHA1_WORDS; gi++) begin : g_pad
        // Padded contents of word gi: keep earlier words, terminate the last
        // word, put 0x80 in the next word if the last was full, zero the rest.
        always_comb begin
            if (4'(gi) < widx) begin
                pad_fill[gi] = blk_buf[gi];
            end else if (4'(gi) == widx) begin
                pad_fill[gi] = blk_buf[gi] | pad;
            end else if ((4'(gi) == widx + 4'd1) && word_full) begin
                pad_fill[gi] = PAD_WORD;
            end else begin
                pad_fill[gi] = 32'h0;
            end
        end
        assign blk_data[511-32*gi -: 32] = blk_buf[gi];
    end

    assign msg_ready = (state == S_FILL);
    assign blk_valid = (state == S_EMIT);
    assign blk_first = first_f;
    assign blk_last  = last_f;

    // Fill / pad / emit / length-only-block sequencer with the block buffer.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= S_FILL;
            widx    <= 4'd0;
            len     <= '0;
            last_nb <= 3'd0;
            first_f <= 1'b1;
            last_f  <= 1'b0;
            need80  <= 1'b0;
            needlen <= 1'b0;
            for (int j = 0; j < SHA1_WORDS; j++) blk_buf[j] <= 32'h0;
        end else begin
            case (state)
                S_FILL: begin
                    if (msg_valid) begin
                        blk_buf[widx] <= msg_data & keep;
                        len           <= len + LEN_W'({eff_nb, 3'b000});
                        last_nb       <= eff_nb;
                        // A short word always ends the message.
                        if (msg_last || !word_full) begin
                            state <= S_PAD;
                        end else if (widx == 4'd15) begin
                            state  <= S_EMIT;
                            last_f <= 1'b0;
                            widx   <= 4'd0;
                        end else begin
                            widx <= widx + 4'd1;
                        end
                    end
                end
                S_PAD: begin
                    for (int j = 0; j < SHA1_WORDS; j++) blk_buf[j] <= pad_fill[j];
                    if (pad_off <= 7'd55) begin
                        blk_buf[14] <= len[63:32];
                        blk_buf[15] <= len[31:0];
                        last_f      <= 1'b1;
                    end else if (pad_off <= 7'd63) begin
                        needlen <= 1'b1;
                        last_f  <= 1'b0;
                    end else begin
                        need80  <= 1'b1;
                        needlen <= 1'b1;
                        last_f  <= 1'b0;
                    end
                    state <= S_EMIT;
                end
                S_EMIT: begin
                    if (blk_ready) begin
                        first_f <= 1'b0;
                        if (last_f) begin
                            len     <= '0;
                            first_f <= 1'b1;
                            widx    <= 4'd0;
                            state   <= S_FILL;
                        end else if (needlen) begin
                            state <= S_EXTRA;
                        end else begin
                            state <= S_FILL;
                        end
                    end
                end
                S_EXTRA: begin
                    for (int j = 0; j < SHA1_WORDS; j++) blk_buf[j] <= 32'h0;
                    blk_buf[0]  <= need80 ? PAD_WORD : 32'h0;
                    blk_buf[14] <= len[63:32];
                    blk_buf[15] <= len[31:0];
                    last_f      <= 1'b1;
                    need80      <= 1'b0;
                    needlen     <= 1'b0;
                    state       <= S_EMIT;
                end
                default: state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_padder.sv
// Bench for sha1_padder: messages are padded by a byte-queue model of the
// SHA-1 padding rule and the emitted blocks are compared block by block.
module tb_sha1_padder;

    logic         clk = 1'b0;
    logic         rstn;
    logic [31:0]  msg_data;
    logic [2:0]   msg_nbytes;
    logic         msg_last;
    logic         msg_valid;
    logic         msg_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;
    logic         blk_valid;
    logic         blk_ready;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0]   msg_q[$];
    logic [511:0] exp_data[$];
    logic         exp_first[$];
    logic         exp_last[$];

    sha1_padder dut (
        .clk        (clk),
        .rstn       (rstn),
        .msg_data   (msg_data),
        .msg_nbytes (msg_nbytes),
        .msg_last   (msg_last),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .blk_data   (blk_data),
        .blk_first  (blk_first),
        .blk_last   (blk_last),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Padding model: message bytes, 0x80, zeros to 56 mod 64, 64-bit length.
    task automatic build_expected();
        logic [7:0]   p[$];
        logic [63:0]  bitlen;
        logic [511:0] d;
        int           nb;
        p = msg_q;
        bitlen = 64'(msg_q.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bitlen[8*i +: 8]);
        nb = p.size() / 64;
        exp_data.delete();
        exp_first.delete();
        exp_last.delete();
        for (int b = 0; b < nb; b++) begin
            d = '0;
            for (int k = 0; k < 64; k++) d[511-8*k -: 8] = p[64*b+k];
            exp_data.push_back(d);
            exp_first.push_back(b == 0);
            exp_last.push_back(b == nb - 1);
        end
    endtask

    // Stream msg_q into the DUT and check every block while it is valid.
    task automatic run_msg(input int tail_empty, input int valid_pct,
                           input int ready_pct, input int stall);
        int n, nwords, wi, bi, cyc, vcnt, pend_lat, acc_cyc, nb;
        logic [31:0] w;
        build_expected();
        n = msg_q.size();
        if (n == 0)                          nwords = 1;
        else if ((n % 4 == 0) && tail_empty != 0) nwords = n / 4 + 1;
        else                                 nwords = (n + 3) / 4;
        wi = 0; bi = 0; cyc = 0; vcnt = 0; pend_lat = 0; acc_cyc = 0;
        while ((wi < nwords || bi < exp_data.size()) && cyc < 5000) begin
            @(negedge clk);
            blk_ready = 1'b0;
            if (blk_valid) begin
                chk("stall_in", 512'(msg_ready), 512'(0));
                if (pend_lat != 0) begin
                    chk("latency", 512'(cyc - acc_cyc), 512'(pend_lat));
                    pend_lat = 0;
                end
                if (bi < exp_data.size()) begin
                    chk("blk_data",  blk_data, exp_data[bi]);
                    chk("blk_first", 512'(blk_first), 512'(exp_first[bi]));
                    chk("blk_last",  512'(blk_last),  512'(exp_last[bi]));
                end else begin
                    chk("extra_blk", 512'(blk_valid), 512'(0));
                end
                blk_ready = (vcnt >= stall) && ($urandom_range(0, 99) < ready_pct);
                vcnt++;
                if (blk_ready) begin
                    bi++;
                    vcnt = 0;
                end
            end
            msg_valid = 1'b0;
            if (msg_ready && wi < nwords && $urandom_range(0, 99) < valid_pct) begin
                if (4 * wi >= n)          nb = 0;
                else if (n - 4 * wi >= 4) nb = 4;
                else                      nb = n - 4 * wi;
                w = $urandom;
                for (int k = 0; k < nb; k++) w[31-8*k -: 8] = msg_q[4*wi+k];
                msg_data   = w;
                msg_nbytes = 3'(nb);
                msg_last   = (wi == nwords - 1);
                msg_valid  = 1'b1;
                if (msg_last) begin
                    pend_lat = 2; acc_cyc = cyc;
                end else if (wi % 16 == 15) begin
                    pend_lat = 1; acc_cyc = cyc;
                end
                wi++;
            end
            cyc++;
        end
        chk("words_done",  512'(wi), 512'(nwords));
        chk("blocks_done", 512'(bi), 512'(exp_data.size()));
        @(negedge clk);
        blk_ready = 1'b0;
        msg_valid = 1'b0;
        chk("idle_valid", 512'(blk_valid), 512'(0));
        chk("idle_ready", 512'(msg_ready), 512'(1));
        $display("msg len=%0d words=%0d blocks=%0d", n, nwords, exp_data.size());
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, 512'(blk_valid), 512'(0));
        chk({tag, "_ready"}, 512'(msg_ready), 512'(1));
        chk({tag, "_first"}, 512'(blk_first), 512'(1));
        chk({tag, "_last"},  512'(blk_last),  512'(0));
        chk({tag, "_data"},  blk_data, 512'(0));
    endtask

    initial begin
        string s;
        int    n;
        rstn = 1'b0; msg_data = '0; msg_nbytes = '0; msg_last = 1'b0;
        msg_valid = 1'b0; blk_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        rstn = 1'b1;
        @(negedge clk);
        check_reset_state("post_rst");

        // "abc"
        msg_q = {8'h61, 8'h62, 8'h63};
        run_msg(0, 100, 100, 0);

        // 56-byte two-block vector
        s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        msg_q.delete();
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
        run_msg(0, 100, 100, 0);

        // 64-byte message, last on word 15, then as 16 words plus empty tail
        msg_q.delete();
        for (int i = 0; i < 64; i++) msg_q.push_back(8'($urandom));
        run_msg(0, 100, 100, 0);
        run_msg(1, 100, 100, 0);

        // empty message
        msg_q.delete();
        run_msg(0, 100, 100, 0);

        // 55-byte message with the block held unaccepted for 10 cycles
        msg_q.delete();
        for (int i = 0; i < 55; i++) msg_q.push_back(8'($urandom));
        run_msg(0, 100, 100, 10);

        // reset while a block is presented
        @(negedge clk);
        msg_data = 32'h61626300; msg_nbytes = 3'd3; msg_last = 1'b1; msg_valid = 1'b1;
        @(negedge clk);
        msg_valid = 1'b0;
        for (int i = 0; i < 10 && !blk_valid; i++) @(negedge clk);
        chk("emit_reached", 512'(blk_valid), 512'(1));
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check_reset_state("mid_rst");
        msg_q = {8'h61, 8'h62, 8'h63};
        run_msg(0, 80, 80, 2);

        // randomized messages with random gaps on both sides
        for (int m = 0; m < 25; m++) begin
            n = $urandom_range(0, 200);
            msg_q.delete();
            for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
            run_msg((n % 4 == 0) ? int'($urandom_range(0, 1)) : 0, 70, 60,
                    int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
